// File: rtl/tri_wave_pkg.sv
// -----------------------------------------------------------------------------
// tri_wave_pkg
// Shared types for the triangular-wave monitor:
//   state_t       - tracking FSM states
//   step_t        - classification of one sample-to-sample step
//   DEFAULT_W     - default sample width
//   classify_step - maps a signed step to step_t
// -----------------------------------------------------------------------------
package tri_wave_pkg;

    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK_UP,
        TRACK_DOWN
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP,
        STEP_DOWN,
        STEP_HOLD,
        STEP_BAD
    } step_t;

    function automatic step_t classify_step(input int delta);
        if (delta == 1)       return STEP_UP;
        else if (delta == -1) return STEP_DOWN;
        else if (delta == 0)  return STEP_HOLD;
        else                  return STEP_BAD;
    endfunction

endpackage

// File: rtl/tri_period_meter.sv
// -----------------------------------------------------------------------------
// tri_period_meter
// Counts valid tracking samples between trough events and publishes the
// trough-to-trough distance as the period.
// Optional build macro: TRI_MON_PERIOD_CHECK_EN (compare each period with the
// previous one and flag differences).
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   tick          - valid sample while tracking (counts toward the period)
//   trough        - this sample is a trough event
//   restart       - step error: drop count, trough history and reference
//   done          - combinational: a period is measured on this sample
//   bad           - combinational: that period differs from the reference
//   period        - last measured period (registered)
//   period_valid  - one-cycle pulse, period updated
//   err_period    - one-cycle pulse, period mismatch
// -----------------------------------------------------------------------------
module tri_period_meter #(
    parameter int unsigned PW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          trough,
    input  logic          restart,
    output logic          done,
    output logic          bad,
    output logic [PW-1:0] period,
    output logic          period_valid,
    output logic          err_period
);

    logic [PW-1:0] count;
    logic [PW-1:0] count_inc;
    logic          trough_seen;

    // The trough sample itself is part of the period it closes.
    assign count_inc = (count == '1) ? count : count + PW'(1);
    assign done      = tick && trough && trough_seen && !restart;

`ifdef TRI_MON_PERIOD_CHECK_EN
    logic [PW-1:0] ref_period;
    logic          ref_valid;

    assign bad = done && ref_valid && (count_inc != ref_period);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_period <= '0;
            ref_valid  <= 1'b0;
        end else if (restart) begin
            ref_valid  <= 1'b0;
        end else if (done) begin
            ref_period <= count_inc;
            ref_valid  <= 1'b1;
        end
    end
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            trough_seen  <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            err_period   <= 1'b0;
        end else begin
            period_valid <= done;
            err_period   <= bad;
            if (restart) begin
                count       <= '0;
                trough_seen <= 1'b0;
            end else if (tick) begin
                if (trough) begin
                    count       <= '0;
                    trough_seen <= 1'b1;
                    if (done) period <= count_inc;
                end else begin
                    count <= count_inc;
                end
            end
        end
    end

endmodule

// File: rtl/triangle_wave_monitor.sv
// -----------------------------------------------------------------------------
// triangle_wave_monitor
// Checks a triangular sample stream (+1 rising, -1 falling, one repeated sample
// at each turnaround), captures peak/trough, measures the period and reports
// contract violations.
// Optional build macro: TRI_MON_PERIOD_CHECK_EN (period-to-period compare).
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   sample_in      - incoming W-bit sample
//   sample_valid   - sample_in valid this cycle (gaps allowed)
//   direction      - 1 rising, 0 falling
//   locked         - LOCK_PERIODS consecutive clean periods seen
//   peak_value     - last captured peak
//   trough_value   - last captured trough
//   period         - last measured period in valid samples (W+2 bits)
//   period_valid   - one-cycle pulse, period updated
//   err_step       - one-cycle pulse, illegal step
//   err_period     - one-cycle pulse, period mismatch (0 without the macro)
//   err_count      - saturating count of err_step + err_period events
// -----------------------------------------------------------------------------
module triangle_wave_monitor
    import tri_wave_pkg::*;
#(
    parameter int unsigned W            = DEFAULT_W,
    parameter int unsigned LOCK_PERIODS = 2,
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [W-1:0]         sample_in,
    input  logic                 sample_valid,
    output logic                 direction,
    output logic                 locked,
    output logic [W-1:0]         peak_value,
    output logic [W-1:0]         trough_value,
    output logic [W+1:0]         period,
    output logic                 period_valid,
    output logic                 err_step,
    output logic                 err_period,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned PW          = W + 2;
    localparam int unsigned LW          = $clog2(LOCK_PERIODS + 1);
    localparam logic [LW-1:0] LOCK_TARGET = LW'(LOCK_PERIODS);

    state_t            state;
    logic [W-1:0]      prev;
    logic              turn;
    logic [LW-1:0]     lock_cnt;
    logic [LW-1:0]     lock_inc;

    logic signed [W:0] delta;
    step_t             step;
    logic              tick;
    logic              peak_evt;
    logic              trough_evt;
    logic              step_bad;
    logic              period_done;
    logic              period_bad;
    logic [ERR_CNT_W:0] err_sum;

    // No wraparound: 255 -> 0 is a step of -255, not +1.
    assign delta = $signed({1'b0, sample_in}) - $signed({1'b0, prev});
    assign step  = classify_step(int'(delta));

    always_comb begin
        tick       = 1'b0;
        peak_evt   = 1'b0;
        trough_evt = 1'b0;
        step_bad   = 1'b0;
        if (sample_valid) begin
            case (state)
                TRACK_UP: begin
                    tick = 1'b1;
                    if (step == STEP_HOLD && !turn) peak_evt = 1'b1;
                    else if (step != STEP_UP)       step_bad = 1'b1;
                end
                TRACK_DOWN: begin
                    tick = 1'b1;
                    if (step == STEP_HOLD && !turn) trough_evt = 1'b1;
                    else if (step != STEP_DOWN)     step_bad   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign lock_inc = (lock_cnt >= LOCK_TARGET) ? lock_cnt : lock_cnt + LW'(1);
    assign err_sum  = {1'b0, err_count}
                    + {{ERR_CNT_W{1'b0}}, step_bad}
                    + {{ERR_CNT_W{1'b0}}, period_bad};

    tri_period_meter #(
        .PW (PW)
    ) u_meter (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .trough       (trough_evt),
        .restart      (step_bad),
        .done         (period_done),
        .bad          (period_bad),
        .period       (period),
        .period_valid (period_valid),
        .err_period   (err_period)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            prev         <= '0;
            turn         <= 1'b0;
            lock_cnt     <= '0;
            direction    <= 1'b1;
            locked       <= 1'b0;
            peak_value   <= '0;
            trough_value <= '0;
            err_step     <= 1'b0;
            err_count    <= '0;
        end else begin
            err_step  <= step_bad;
            err_count <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];

            if (step_bad || period_bad) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else if (period_done) begin
                lock_cnt <= lock_inc;
                locked   <= (lock_inc >= LOCK_TARGET);
            end

            if (sample_valid) begin
                prev <= sample_in;
                case (state)
                    IDLE: state <= ACQUIRE;
                    ACQUIRE: begin
                        if (step == STEP_UP) begin
                            state     <= TRACK_UP;
                            direction <= 1'b1;
                            turn      <= 1'b0;
                        end else if (step == STEP_DOWN) begin
                            state     <= TRACK_DOWN;
                            direction <= 1'b0;
                            turn      <= 1'b0;
                        end
                    end
                    TRACK_UP: begin
                        if (step_bad) begin
                            state <= ACQUIRE;
                            turn  <= 1'b0;
                        end else if (peak_evt) begin
                            peak_value <= sample_in;
                            direction  <= 1'b0;
                            turn       <= 1'b1;
                            state      <= TRACK_DOWN;
                        end else begin
                            turn <= 1'b0;
                        end
                    end
                    TRACK_DOWN: begin
                        if (step_bad) begin
                            state <= ACQUIRE;
                            turn  <= 1'b0;
                        end else if (trough_evt) begin
                            trough_value <= sample_in;
                            direction    <= 1'b1;
                            turn         <= 1'b1;
                            state        <= TRACK_UP;
                        end else begin
                            turn <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_triangle_wave_monitor.sv
// -----------------------------------------------------------------------------
// tb_triangle_wave_monitor
// Directed and randomized stream checks of triangle_wave_monitor against a
// sample-by-sample behavioural model of the generator contract.
// Honours TRI_MON_PERIOD_CHECK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_triangle_wave_monitor;

    localparam int W       = 8;
    localparam int LP      = 2;
    localparam int ECW     = 8;
    localparam int PW      = W + 2;
    localparam int ERR_MAX = (1 << ECW) - 1;
    localparam int CNT_MAX = (1 << PW) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   sample_in;
    logic           sample_valid;
    logic           direction;
    logic           locked;
    logic [W-1:0]   peak_value;
    logic [W-1:0]   trough_value;
    logic [PW-1:0]  period;
    logic           period_valid;
    logic           err_step;
    logic           err_period;
    logic [ECW-1:0] err_count;

    int tests    = 0;
    int failures = 0;
    bit gaps_on  = 1'b0;

    // Reference model: the stream seen so far, reduced to a few facts.
    bit m_started, m_tracking, m_held, m_seen, m_ref_valid;
    int m_prev, m_count, m_lock, m_ref;
    int e_dir, e_locked, e_peak, e_trough, e_period, e_pv, e_es, e_ep, e_errc;

    triangle_wave_monitor #(
        .W            (W),
        .LOCK_PERIODS (LP),
        .ERR_CNT_W    (ECW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .direction    (direction),
        .locked       (locked),
        .peak_value   (peak_value),
        .trough_value (trough_value),
        .period       (period),
        .period_valid (period_valid),
        .err_step     (err_step),
        .err_period   (err_period),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_tracking = 0; m_held = 0; m_seen = 0; m_ref_valid = 0;
        m_prev = 0; m_count = 0; m_lock = 0; m_ref = 0;
        e_dir = 1; e_locked = 0; e_peak = 0; e_trough = 0; e_period = 0;
        e_pv = 0; e_es = 0; e_ep = 0; e_errc = 0;
    endtask

    task automatic bump_err();
        e_errc = (e_errc < ERR_MAX) ? e_errc + 1 : ERR_MAX;
    endtask

    task automatic measured(input int p);
        e_period = p;
        e_pv     = 1;
`ifdef TRI_MON_PERIOD_CHECK_EN
        if (m_ref_valid && p != m_ref) begin
            e_ep = 1;
            bump_err();
            m_lock   = 0;
            e_locked = 0;
        end else begin
            m_lock++;
            e_locked = (m_lock >= LP);
        end
        m_ref       = p;
        m_ref_valid = 1;
`else
        m_lock++;
        e_locked = (m_lock >= LP);
`endif
    endtask

    task automatic model_sample(input int s);
        int d;
        d = s - m_prev;
        e_pv = 0; e_es = 0; e_ep = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (!m_tracking) begin
            if (d == 1 || d == -1) begin
                m_tracking = 1;
                m_held     = 0;
                e_dir      = (d == 1);
            end
        end else begin
            m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
            if (d == (e_dir ? 1 : -1)) begin
                m_held = 0;
            end else if (d == 0 && !m_held) begin
                m_held = 1;
                if (e_dir == 1) begin
                    e_peak = s;
                end else begin
                    e_trough = s;
                    if (m_seen) measured(m_count);
                    m_seen  = 1;
                    m_count = 0;
                end
                e_dir = 1 - e_dir;
            end else begin
                e_es = 1;
                bump_err();
                m_lock = 0; e_locked = 0;
                m_tracking = 0; m_seen = 0; m_count = 0; m_held = 0; m_ref_valid = 0;
            end
        end
        m_prev = s;
    endtask

    task automatic check_all(input string where);
        chk({where, ".direction"},    32'(direction),    32'(e_dir));
        chk({where, ".locked"},       32'(locked),       32'(e_locked));
        chk({where, ".peak_value"},   32'(peak_value),   32'(e_peak));
        chk({where, ".trough_value"}, 32'(trough_value), 32'(e_trough));
        chk({where, ".period"},       32'(period),       32'(e_period));
        chk({where, ".period_valid"}, 32'(period_valid), 32'(e_pv));
        chk({where, ".err_step"},     32'(err_step),     32'(e_es));
        chk({where, ".err_period"},   32'(err_period),   32'(e_ep));
        chk({where, ".err_count"},    32'(err_count),    32'(e_errc));
    endtask

    task automatic drive(input bit v, input int s);
        @(negedge clk);
        sample_valid = v;
        sample_in    = 8'(s);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        if (v) model_sample(s);
        else begin
            e_pv = 0; e_es = 0; e_ep = 0;
        end
        check_all(v ? "sample" : "gap");
    endtask

    task automatic send(input int s);
        if (gaps_on && $urandom_range(0, 3) == 0) begin
            int n;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 255));
        end
        drive(1'b1, s);
    endtask

    task automatic ramp(input int a, input int b);
        if (a <= b) for (int v = a; v <= b; v++) send(v);
        else        for (int v = a; v >= b; v--) send(v);
    endtask

    // One generator period starting just after a trough hold at 0.
    task automatic wave_period(input int amp);
        ramp(1, amp);
        send(amp);
        ramp(amp - 1, 0);
        send(0);
    endtask

    task automatic check_reset_values(input string where);
        chk({where, ".dir_rst"},    32'(direction),    32'd1);
        chk({where, ".lock_rst"},   32'(locked),       32'd0);
        chk({where, ".peak_rst"},   32'(peak_value),   32'd0);
        chk({where, ".trough_rst"}, 32'(trough_value), 32'd0);
        chk({where, ".period_rst"}, 32'(period),       32'd0);
        chk({where, ".errc_rst"},   32'(err_count),    32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        model_reset();
        #12;
        check_reset_values("reset");
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Small ramp 0..3..0, two periods, then a third to reach lock.
        send(0);
        wave_period(3);
        wave_period(3);
        chk("tp.period",       32'(period),       32'd8);
        chk("tp.period_valid", 32'(period_valid), 32'd1);
        chk("tp.peak",         32'(peak_value),   32'd3);
        chk("tp.trough",       32'(trough_value), 32'd0);
        chk("tp.err_count",    32'(err_count),    32'd0);
        chk("tp.not_locked",   32'(locked),       32'd0);
        wave_period(3);
        chk("tp.locked",       32'(locked),       32'd1);

        // Full 8-bit sweeps.
        wave_period(255);
        wave_period(255);
        chk("sweep.period",       32'(period),       32'd512);
        chk("sweep.period_valid", 32'(period_valid), 32'd1);
        chk("sweep.peak",         32'(peak_value),   32'd255);

        // 5 -> 7 while rising, then recovery.
        ramp(1, 5);
        send(7);
        chk("inj.err_step", 32'(err_step), 32'd1);
        chk("inj.locked",   32'(locked),   32'd0);
`ifndef TRI_MON_PERIOD_CHECK_EN
        chk("inj.err_count", 32'(err_count), 32'd1);
`endif
        ramp(6, 0);
        send(0);
        wave_period(3);
        wave_period(3);
        chk("recover.locked", 32'(locked), 32'd1);

        // Triple hold at a peak, then a 255 -> 0 jump.
        ramp(1, 3);
        send(3);
        send(3);
        chk("hold3.err_step", 32'(err_step), 32'd1);
        ramp(4, 255);
        send(0);
        chk("wrap.err_step", 32'(err_step), 32'd1);

        // Period 8 followed by period 10.
        wave_period(3);
        wave_period(3);
        wave_period(4);
        chk("p8p10.period", 32'(period), 32'd10);
`ifdef TRI_MON_PERIOD_CHECK_EN
        chk("p8p10.err_period", 32'(err_period), 32'd1);
        chk("p8p10.locked",     32'(locked),     32'd0);
`else
        chk("p8p10.err_period", 32'(err_period), 32'd0);
`endif

        // Gaps mid-ramp, then asynchronous reset mid-ramp.
        ramp(1, 3);
        for (int i = 0; i < 5; i++) drive(1'b0, $urandom_range(0, 255));
        chk("gap.direction", 32'(direction), 32'd1);
        ramp(4, 6);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_values("midreset");
        check_all("midreset");
        @(negedge clk);
        reset = 1'b0;

        // Randomized periods with gaps and occasional glitches.
        gaps_on = 1'b1;
        send(0);
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 99) < 15) send($urandom_range(0, 255));
            else wave_period($urandom_range(2, 12));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
